// File: rtl/sonar_pkg.sv
// sonar_pkg: shared FSM states, distance ceiling and us-to-cycles helper for the sonar scanner
package sonar_pkg;
  typedef enum logic [2:0] {OCIOSO, DISPARA, ESPERA_ECO, MEDE, ARMAZENA, INTERVALO, FIM} estado_t;
  localparam logic [9:0] DIST_MAX = 10'd1023;
  function automatic int us_para_ciclos(input int clk_hz, input int us);
    return int'((longint'(clk_hz) * longint'(us)) / longint'(1_000_000));
  endfunction
endpackage

// File: rtl/contador_cm.sv
// contador_cm: cycle-mod-CICLOS_CM divider feeding a saturating cm counter; SONAR_ARREDONDA_EN rounds half-up
module contador_cm
  import sonar_pkg::*;
#(
  parameter int CICLOS_CM = 2941
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa,
  input  logic       conta,
  output logic [9:0] cm
);
  localparam int W = $clog2(CICLOS_CM + 1);
  logic [W-1:0] ciclo_q, ciclo_d;
  logic [9:0]   cm_q, cm_d;
  logic         wrap;
  // divider/counter next state, saturation and the presented (optionally rounded) result
  always_comb begin
    wrap = ciclo_q == W'(CICLOS_CM - 1);
    ciclo_d = limpa ? '0 : !conta ? ciclo_q : wrap ? '0 : ciclo_q + W'(1);
    cm_d = limpa ? '0 : (conta && wrap && cm_q != DIST_MAX) ? cm_q + 10'd1 : cm_q;
`ifdef SONAR_ARREDONDA_EN
    cm = (ciclo_q >= W'((CICLOS_CM + 1) / 2) && cm_q != DIST_MAX) ? cm_q + 10'd1 : cm_q;
`else
    cm = cm_q;
`endif
  end
  // counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ciclo_q <= '0;
      cm_q <= '0;
    end else begin
      ciclo_q <= ciclo_d;
      cm_q <= cm_d;
    end
  end
endmodule

// File: rtl/medidor_sonar_multi.sv
// medidor_sonar_multi: sequential multi-channel ultrasonic ranger; define SONAR_ARREDONDA_EN for rounded cm
module medidor_sonar_multi
  import sonar_pkg::*;
#(
  parameter int N_CANAIS   = 3,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 1000,
  parameter int CICLOS_CM  = 2941
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ligar,
  input  logic                    modo_continuo,
  input  logic [N_CANAIS-1:0]     echo,
  output logic [N_CANAIS-1:0]     trigger,
  output logic [10*N_CANAIS-1:0]  distancia,
  output logic [N_CANAIS-1:0]     erro,
  output logic [2:0]              canal,
  output logic                    ocupado,
  output logic                    pronto
);
  localparam int T_TRIG = us_para_ciclos(CLK_HZ, TRIG_US);
  localparam int T_TO   = us_para_ciclos(CLK_HZ, TIMEOUT_US);
  localparam int T_GAP  = us_para_ciclos(CLK_HZ, GAP_US);
  localparam logic [31:0] TRIG_M1 = 32'(T_TRIG > 1 ? T_TRIG - 1 : 0);
  localparam logic [31:0] TO_M1   = 32'(T_TO > 1 ? T_TO - 1 : 0);
  localparam logic [31:0] GAP_M1  = 32'(T_GAP > 1 ? T_GAP - 1 : 0);
  estado_t                 estado_q, estado_d;
  logic [2:0]              canal_q, canal_d;
  logic [31:0]             tmr_q, tmr_d;
  logic                    to_q, to_d;
  logic [10*N_CANAIS-1:0]  dist_q, dist_d;
  logic [N_CANAIS-1:0]     erro_q, erro_d;
  logic [N_CANAIS-1:0]     s1_q, sync_q, prev_q;
  logic                    e_s, e_p;
  logic [9:0]              cm;
  contador_cm #(.CICLOS_CM(CICLOS_CM)) u_cm (
    .clock (clock),
    .reset (reset),
    .limpa (estado_q == ESPERA_ECO),
    .conta (estado_q == MEDE),
    .cm    (cm)
  );
  // scan sequencing, per-channel result capture and outputs
  always_comb begin
    estado_d = estado_q;
    canal_d = canal_q;
    to_d = to_q;
    dist_d = dist_q;
    erro_d = erro_q;
    e_s = 1'b0;
    e_p = 1'b0;
    trigger = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      if (canal_q == 3'(i)) begin
        e_s = sync_q[i];
        e_p = prev_q[i];
        trigger[i] = estado_q == DISPARA;
      end
    end
    case (estado_q)
      OCIOSO: if (ligar || modo_continuo) begin
        estado_d = DISPARA;
        canal_d = '0;
        to_d = 1'b0;
      end
      DISPARA: if (tmr_q == TRIG_M1) estado_d = ESPERA_ECO;
      ESPERA_ECO: begin
        if (e_s && !e_p) estado_d = MEDE;
        else if (tmr_q == TO_M1) begin
          estado_d = ARMAZENA;
          to_d = 1'b1;
        end
      end
      MEDE: begin
        if (!e_s && e_p) estado_d = ARMAZENA;
        else if (tmr_q == TO_M1) begin
          estado_d = ARMAZENA;
          to_d = 1'b1;
        end
      end
      ARMAZENA: begin
        for (int i = 0; i < N_CANAIS; i++) begin
          if (canal_q == 3'(i)) begin
            dist_d[10*i +: 10] = to_q ? DIST_MAX : cm;
            erro_d[i] = to_q;
          end
        end
        estado_d = (canal_q < 3'(N_CANAIS - 1)) ? INTERVALO : FIM;
      end
      INTERVALO: if (tmr_q == GAP_M1) begin
        estado_d = DISPARA;
        canal_d = canal_q + 3'd1;
        to_d = 1'b0;
      end
      FIM: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    tmr_d = (estado_d != estado_q) ? '0 : tmr_q + 32'd1;
    distancia = dist_q;
    erro = erro_q;
    canal = canal_q;
    ocupado = estado_q != OCIOSO && estado_q != FIM;
    pronto = estado_q == FIM;
  end
  // state register and stored results
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      canal_q <= '0;
      tmr_q <= '0;
      to_q <= 1'b0;
      dist_q <= '0;
      erro_q <= '0;
    end else begin
      estado_q <= estado_d;
      canal_q <= canal_d;
      tmr_q <= tmr_d;
      to_q <= to_d;
      dist_q <= dist_d;
      erro_q <= erro_d;
    end
  end
  // two-stage echo synchronizer plus previous-value register for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q <= echo;
      sync_q <= s1_q;
      prev_q <= sync_q;
    end
  end
endmodule
